// File: rtl/or1200_pipemon_pkg.sv
// Shared types and helpers for the or1200 pipeline-protocol monitor.
package or1200_pipemon_pkg;

   typedef enum logic [1:0] {
      R_FLUSH   = 2'd0,
      R_HOLD    = 2'd1,
      R_BUBBLE  = 2'd2,
      R_ADVANCE = 2'd3
   } rule_e;

   localparam logic [31:0] NOP_INSN_DEFAULT = 32'h1441_0000;

   // ceil(log2(n)), but never below 1 so index ports always have a bit
   function automatic int clog2_min1(input int n);
      int r;
      r = 0;
      for (int p = 1; p < n; p = p * 2) r = r + 1;
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/or1200_pipemon_stage.sv
// One-stage rule checker: derives the 4-bit violation vector from the previous
// and current samples of this stage and the previous sample of its upstream stage.
module or1200_pipemon_stage
   import or1200_pipemon_pkg::*;
#(
   parameter int                 INSN_W   = 32,
   parameter logic [INSN_W-1:0]  NOP_INSN = INSN_W'(NOP_INSN_DEFAULT),
   parameter bit                 HAS_UP   = 1'b1
) (
   input  logic [INSN_W-1:0] prev_insn,
   input  logic [INSN_W-1:0] cur_insn,
   input  logic              prev_freeze,
   input  logic              prev_flush,
   input  logic [INSN_W-1:0] up_prev_insn,
   input  logic              up_prev_freeze,
   output logic [3:0]        viol
);

   // Exactly one rule governs the stage; flush outranks freeze outranks upstream state.
   always_comb begin
      viol = '0;
      if (prev_flush) begin
         viol[R_FLUSH] = (cur_insn != NOP_INSN);
      end else if (prev_freeze) begin
         viol[R_HOLD] = (cur_insn != prev_insn);
      end else if (HAS_UP) begin
         if (up_prev_freeze) begin
            viol[R_BUBBLE] = (cur_insn != NOP_INSN);
         end else begin
            viol[R_ADVANCE] = (cur_insn != up_prev_insn);
         end
      end
   end

endmodule

// File: rtl/or1200_pipe_monitor.sv
// Runtime freeze/flush/bubble/advance monitor for the or1200 pipeline chain.
// Optional OR1200_PIPEMON_TIMESTAMP_EN adds a cycle counter and first_time capture.
module or1200_pipe_monitor
   import or1200_pipemon_pkg::*;
#(
   parameter int                 NSTAGE   = 4,
   parameter int                 INSN_W   = 32,
   parameter logic [INSN_W-1:0]  NOP_INSN = INSN_W'(NOP_INSN_DEFAULT),
   parameter int                 CNT_W    = 16
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [NSTAGE*INSN_W-1:0]          stage_insn,
   input  logic [NSTAGE-1:0]                 stage_freeze,
   input  logic [NSTAGE-1:0]                 stage_flush,
   input  logic                              mon_en,
   input  logic                              clr,
   output logic [NSTAGE*4-1:0]               err_vec,
   output logic                              err_any,
   output logic [CNT_W-1:0]                  err_cnt,
   output logic                              first_valid,
   output logic [clog2_min1(NSTAGE)-1:0]     first_stage,
   output logic [1:0]                        first_rule
`ifdef OR1200_PIPEMON_TIMESTAMP_EN
   ,
   output logic [CNT_W-1:0]                  first_time
`endif
);

   localparam int SW = clog2_min1(NSTAGE);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [NSTAGE*INSN_W-1:0] insn_q, insn_d;
   logic [NSTAGE-1:0]        freeze_q, freeze_d;
   logic [NSTAGE-1:0]        flush_q, flush_d;
   logic                     armed_q, armed_d;
   logic [NSTAGE*4-1:0]      err_vec_q, err_vec_d;
   logic [CNT_W-1:0]         err_cnt_q, err_cnt_d;
   logic                     first_valid_q, first_valid_d;
   logic [SW-1:0]            first_stage_q, first_stage_d;
   rule_e                    first_rule_q, first_rule_d;

   logic [NSTAGE*4-1:0]      viol_raw;
   logic [NSTAGE*4-1:0]      viol_chk;
   logic                     viol_any;
   logic [SW-1:0]            hit_stage;
   rule_e                    hit_rule;

   for (genvar s = 0; s < NSTAGE; s++) begin : g_stage
      logic [INSN_W-1:0] up_insn;
      logic              up_freeze;
      if (s == 0) begin : g_head
         assign up_insn   = '0;
         assign up_freeze = 1'b0;
      end else begin : g_up
         assign up_insn   = insn_q[(s-1)*INSN_W +: INSN_W];
         assign up_freeze = freeze_q[s-1];
      end
      or1200_pipemon_stage #(
         .INSN_W   (INSN_W),
         .NOP_INSN (NOP_INSN),
         .HAS_UP   (s > 0)
      ) u_stage (
         .prev_insn      (insn_q[s*INSN_W +: INSN_W]),
         .cur_insn       (stage_insn[s*INSN_W +: INSN_W]),
         .prev_freeze    (freeze_q[s]),
         .prev_flush     (flush_q[s]),
         .up_prev_insn   (up_insn),
         .up_prev_freeze (up_freeze),
         .viol           (viol_raw[s*4 +: 4])
      );
   end

   // mon_en gates the current cycle too, so dropping it suspends checks at once
   assign viol_chk = (armed_q && mon_en) ? viol_raw : '0;
   assign viol_any = |viol_chk;

   // Scan downward so the lowest stage, then lowest rule, is the last to win.
   always_comb begin
      hit_stage = '0;
      hit_rule  = R_FLUSH;
      for (int s = NSTAGE - 1; s >= 0; s--) begin
         for (int r = 3; r >= 0; r--) begin
            if (viol_chk[s*4 + r]) begin
               hit_stage = SW'(s);
               hit_rule  = rule_e'(2'(r));
            end
         end
      end
   end

   always_comb begin
      armed_d       = mon_en;
      insn_d        = stage_insn;
      freeze_d      = stage_freeze;
      flush_d       = stage_flush;
      err_vec_d     = err_vec_q;
      err_cnt_d     = err_cnt_q;
      first_valid_d = first_valid_q;
      first_stage_d = first_stage_q;
      first_rule_d  = first_rule_q;
      if (clr) begin
         err_vec_d     = '0;
         err_cnt_d     = '0;
         first_valid_d = 1'b0;
         first_stage_d = '0;
         first_rule_d  = R_FLUSH;
      end else if (viol_any) begin
         err_vec_d = err_vec_q | viol_chk;
         if (err_cnt_q != CNT_MAX) err_cnt_d = err_cnt_q + CNT_W'(1);
         if (!first_valid_q) begin
            first_valid_d = 1'b1;
            first_stage_d = hit_stage;
            first_rule_d  = hit_rule;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         insn_q        <= '0;
         freeze_q      <= '0;
         flush_q       <= '0;
         armed_q       <= 1'b0;
         err_vec_q     <= '0;
         err_cnt_q     <= '0;
         first_valid_q <= 1'b0;
         first_stage_q <= '0;
         first_rule_q  <= R_FLUSH;
      end else begin
         insn_q        <= insn_d;
         freeze_q      <= freeze_d;
         flush_q       <= flush_d;
         armed_q       <= armed_d;
         err_vec_q     <= err_vec_d;
         err_cnt_q     <= err_cnt_d;
         first_valid_q <= first_valid_d;
         first_stage_q <= first_stage_d;
         first_rule_q  <= first_rule_d;
      end
   end

`ifdef OR1200_PIPEMON_TIMESTAMP_EN
   logic [CNT_W-1:0] ts_q, ts_d;
   logic [CNT_W-1:0] first_time_q, first_time_d;

   always_comb begin
      ts_d         = clr ? '0 : ts_q + CNT_W'(1);
      first_time_d = first_time_q;
      if (clr) begin
         first_time_d = '0;
      end else if (viol_any && !first_valid_q) begin
         first_time_d = ts_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ts_q         <= '0;
         first_time_q <= '0;
      end else begin
         ts_q         <= ts_d;
         first_time_q <= first_time_d;
      end
   end

   assign first_time = first_time_q;
`endif

   assign err_vec     = err_vec_q;
   assign err_any     = |err_vec_q;
   assign err_cnt     = err_cnt_q;
   assign first_valid = first_valid_q;
   assign first_stage = first_stage_q;
   assign first_rule  = first_rule_q;

endmodule

// File: tb/tb_or1200_pipe_monitor.sv
// Bench for or1200_pipe_monitor: directed scenarios plus randomized pipeline traffic,
// checked against a rule-level reference model (two instances, CNT_W=16 and CNT_W=4).
module tb_or1200_pipe_monitor;
   import or1200_pipemon_pkg::*;

   localparam int NS  = 4;
   localparam int IW  = 32;
   localparam int CWA = 16;
   localparam int CWB = 4;
   localparam logic [31:0] NOP = 32'h1441_0000;

   logic            clk = 1'b0;
   logic            rst;
   logic [31:0]     insn [NS];
   logic [NS-1:0]   frz, fls;
   logic            mon_en, clr;
   logic [NS*IW-1:0] stage_insn;

   for (genvar s = 0; s < NS; s++) begin : g_pack
      assign stage_insn[s*IW +: IW] = insn[s];
   end

   logic [NS*4-1:0] a_err_vec, b_err_vec;
   logic            a_err_any, b_err_any;
   logic [CWA-1:0]  a_err_cnt;
   logic [CWB-1:0]  b_err_cnt;
   logic            a_first_valid, b_first_valid;
   logic [1:0]      a_first_stage, b_first_stage;
   logic [1:0]      a_first_rule, b_first_rule;
`ifdef OR1200_PIPEMON_TIMESTAMP_EN
   logic [CWA-1:0]  a_first_time;
   logic [CWB-1:0]  b_first_time;
`endif

   or1200_pipe_monitor #(.NSTAGE(NS), .INSN_W(IW), .NOP_INSN(NOP), .CNT_W(CWA)) dut_a (
      .clk(clk), .rst(rst), .stage_insn(stage_insn), .stage_freeze(frz), .stage_flush(fls),
      .mon_en(mon_en), .clr(clr), .err_vec(a_err_vec), .err_any(a_err_any), .err_cnt(a_err_cnt),
      .first_valid(a_first_valid), .first_stage(a_first_stage), .first_rule(a_first_rule)
`ifdef OR1200_PIPEMON_TIMESTAMP_EN
      , .first_time(a_first_time)
`endif
   );

   or1200_pipe_monitor #(.NSTAGE(NS), .INSN_W(IW), .NOP_INSN(NOP), .CNT_W(CWB)) dut_b (
      .clk(clk), .rst(rst), .stage_insn(stage_insn), .stage_freeze(frz), .stage_flush(fls),
      .mon_en(mon_en), .clr(clr), .err_vec(b_err_vec), .err_any(b_err_any), .err_cnt(b_err_cnt),
      .first_valid(b_first_valid), .first_stage(b_first_stage), .first_rule(b_first_rule)
`ifdef OR1200_PIPEMON_TIMESTAMP_EN
      , .first_time(b_first_time)
`endif
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // reference model state; index 0 = 16-bit counter instance, 1 = 4-bit
   logic [31:0]     m_pinsn [NS];
   logic [NS-1:0]   m_pfrz, m_pfls;
   bit              m_armed;
   logic [NS*4-1:0] m_vec;
   bit              m_fv;
   int              m_fs, m_fr;
   int              m_cnt [2];
   int              m_ts  [2];
   int              m_ft  [2];
   int              lim   [2] = '{(1 << CWA) - 1, (1 << CWB) - 1};

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int s = 0; s < NS; s++) m_pinsn[s] = '0;
      m_pfrz = '0; m_pfls = '0; m_armed = 0; m_vec = '0; m_fv = 0; m_fs = 0; m_fr = 0;
      for (int k = 0; k < 2; k++) begin m_cnt[k] = 0; m_ts[k] = 0; m_ft[k] = 0; end
   endtask

   task automatic compare_all();
      chk("a_err_vec", 64'(a_err_vec), 64'(m_vec));
      chk("a_err_any", 64'(a_err_any), 64'(m_vec != 0));
      chk("a_err_cnt", 64'(a_err_cnt), 64'(m_cnt[0]));
      chk("a_first_valid", 64'(a_first_valid), 64'(m_fv));
      chk("a_first_stage", 64'(a_first_stage), 64'(m_fs));
      chk("a_first_rule", 64'(a_first_rule), 64'(m_fr));
      chk("b_err_vec", 64'(b_err_vec), 64'(m_vec));
      chk("b_err_cnt", 64'(b_err_cnt), 64'(m_cnt[1]));
      chk("b_first_stage", 64'(b_first_stage), 64'(m_fs));
`ifdef OR1200_PIPEMON_TIMESTAMP_EN
      chk("a_first_time", 64'(a_first_time), 64'(m_ft[0]));
      chk("b_first_time", 64'(b_first_time), 64'(m_ft[1]));
`endif
   endtask

   // Evaluate the protocol rules on the current inputs, clock once, then compare.
   task automatic cyc();
      logic [NS*4-1:0] nv;
      int  r;
      bit  bad, found;
      nv = '0;
      for (int s = 0; s < NS; s++) begin
         r = -1; bad = 0;
         if (m_pfls[s]) begin r = 0; bad = (insn[s] !== NOP); end
         else if (m_pfrz[s]) begin r = 1; bad = (insn[s] !== m_pinsn[s]); end
         else if (s > 0) begin
            if (m_pfrz[s-1]) begin r = 2; bad = (insn[s] !== NOP); end
            else begin r = 3; bad = (insn[s] !== m_pinsn[s-1]); end
         end
         if (m_armed && mon_en && r >= 0 && bad) nv[s*4 + r] = 1'b1;
      end
      @(posedge clk);
      if (rst) model_reset();
      else begin
         if (clr) begin
            m_vec = '0; m_fv = 0; m_fs = 0; m_fr = 0;
            for (int k = 0; k < 2; k++) begin m_cnt[k] = 0; m_ts[k] = 0; m_ft[k] = 0; end
         end else begin
            if (nv != 0) begin
               m_vec = m_vec | nv;
               for (int k = 0; k < 2; k++) if (m_cnt[k] < lim[k]) m_cnt[k]++;
               if (!m_fv) begin
                  found = 0;
                  for (int s = 0; s < NS; s++)
                     for (int q = 0; q < 4; q++)
                        if (!found && nv[s*4 + q]) begin found = 1; m_fs = s; m_fr = q; end
                  m_fv = 1;
                  for (int k = 0; k < 2; k++) m_ft[k] = m_ts[k];
               end
            end
            for (int k = 0; k < 2; k++) m_ts[k] = (m_ts[k] + 1) % (lim[k] + 1);
         end
         m_pinsn = insn; m_pfrz = frz; m_pfls = fls; m_armed = mon_en;
      end
      @(negedge clk);
      compare_all();
   endtask

   // Instruction values that obey every rule given the inputs currently applied.
   task automatic legal_next();
      logic [31:0] n [NS];
      for (int s = 0; s < NS; s++) begin
         if (fls[s]) n[s] = NOP;
         else if (frz[s]) n[s] = insn[s];
         else if (s == 0) n[s] = $urandom;
         else if (frz[s-1]) n[s] = NOP;
         else n[s] = insn[s-1];
      end
      insn = n;
   endtask

   task automatic rand_ctrl();
      for (int s = 0; s < NS; s++) begin
         frz[s] = ($urandom % 4) == 0;
         fls[s] = ($urandom % 12) == 0;
      end
   endtask

   initial begin
      rst = 1'b1; mon_en = 1'b0; clr = 1'b0; frz = '0; fls = '0;
      for (int s = 0; s < NS; s++) insn[s] = $urandom;
      model_reset();
      #3;
      compare_all();
      chk("reset_err_any", 64'(a_err_any), 64'(0));
      @(negedge clk);
      cyc();
      rst = 1'b0; mon_en = 1'b1;

      // clean traffic
      for (int i = 0; i < 100; i++) begin
         legal_next(); rand_ctrl(); cyc();
      end
      chk("clean_err_any", 64'(a_err_any), 64'(0));
      chk("clean_err_cnt", 64'(a_err_cnt), 64'(0));
      chk("clean_first_valid", 64'(a_first_valid), 64'(0));

      // stage 2 flush followed by a non-NOP
      legal_next(); frz = '0; fls = '0; clr = 1'b1; cyc(); clr = 1'b0;
      legal_next(); fls = 4'b0100; cyc();
      legal_next(); insn[2] = 32'h9C21_0004; fls = '0; cyc();
      chk("flush_err_vec", 64'(a_err_vec), 64'h0100);
      chk("flush_err_cnt", 64'(a_err_cnt), 64'd1);
      chk("flush_first_stage", 64'(a_first_stage), 64'd2);
      chk("flush_first_rule", 64'(a_first_rule), 64'd0);

      // stage 1 hold breach together with stage 3 advance breach
      legal_next(); insn[0] = 32'hE083_2000; clr = 1'b1; cyc(); clr = 1'b0;
      legal_next(); frz = 4'b0010; cyc();
      legal_next(); insn[1] = 32'hE083_2001; insn[3] = ~insn[3]; frz = '0; cyc();
      chk("hold_first_stage", 64'(a_first_stage), 64'd1);
      chk("hold_first_rule", 64'(a_first_rule), 64'd1);
      chk("hold_err_cnt", 64'(a_err_cnt), 64'd1);
      chk("hold_err_vec", 64'(a_err_vec), 64'h8020);

      // violation every cycle: small counter saturates
      legal_next(); clr = 1'b1; cyc(); clr = 1'b0;
      for (int i = 0; i < 21; i++) begin
         legal_next(); insn[0] = $urandom | 32'h1; fls = 4'b0001; cyc();
      end
      chk("sat_b_err_cnt", 64'(b_err_cnt), 64'd15);
      chk("sat_a_err_cnt", 64'(a_err_cnt), 64'd20);

      // clear beats a same-cycle violation
      legal_next(); insn[0] = $urandom | 32'h1; clr = 1'b1; cyc(); clr = 1'b0;
      chk("clr_err_vec", 64'(a_err_vec), 64'd0);
      chk("clr_err_cnt", 64'(a_err_cnt), 64'd0);
      chk("clr_first_valid", 64'(a_first_valid), 64'd0);
      legal_next(); insn[0] = $urandom | 32'h1; cyc();
      chk("post_clr_err_cnt", 64'(a_err_cnt), 64'd1);

      // async reset in the middle of a violation stream
      for (int i = 0; i < 3; i++) begin
         legal_next(); insn[0] = $urandom | 32'h1; cyc();
      end
      #2 rst = 1'b1; model_reset();
      #1;
      compare_all();
      chk("rst_err_any", 64'(a_err_any), 64'd0);
      @(negedge clk);
      cyc();
      rst = 1'b0;
      for (int s = 0; s < NS; s++) insn[s] = $urandom | 32'h1;
      cyc();
      chk("unarmed_err_any", 64'(a_err_any), 64'd0);
      for (int i = 0; i < 10; i++) begin
         legal_next(); rand_ctrl(); cyc();
      end
      chk("rearm_err_any", 64'(a_err_any), 64'd0);

      // randomized traffic with injected faults, enable drops and clears
      for (int i = 0; i < 300; i++) begin
         legal_next(); rand_ctrl();
         if (($urandom % 16) == 0) begin
            int k;
            k = $urandom_range(0, NS - 1);
            insn[k] = insn[k] ^ ($urandom | 32'h1);
         end
         mon_en = ($urandom % 20) != 0;
         clr = ($urandom % 40) == 0;
         cyc();
      end
      clr = 1'b0; mon_en = 1'b1;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
